// File: rtl/votacao_lobinho.sv
// Day-phase ballot collector for PoliLobinho: seat-ordered voting, tally, result.
// Optional VOTO_NULO_EN: alvo=3'b111 counts as a valid abstention.
module votacao_lobinho #(
  parameter int N_JOGADORES = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic [N_JOGADORES-1:0] vivos,
  input  logic [2:0]             alvo,
  input  logic                   confirma,
  output logic [2:0]             eleitor_atual,
  output logic                   votando,
  output logic                   voto_invalido,
  output logic                   pronto,
  output logic [2:0]             eliminado,
  output logic                   empate,
  output logic [3:0]             db_estado
);

  typedef enum logic [3:0] {
    OCIOSO      = 4'd0,
    PREPARA     = 4'd1,
    ESPERA_VOTO = 4'd2,
    REGISTRA    = 4'd3,
    PROXIMO     = 4'd4,
    APURA       = 4'd5,
    RESULTADO   = 4'd6
  } estado_t;

  localparam logic [2:0] NJ     = 3'(N_JOGADORES);
  localparam logic [2:0] ULTIMO = 3'(N_JOGADORES - 1);

  estado_t r_estado, w_prox_estado;

  logic [N_JOGADORES-1:0] r_vivos;
  logic [2:0] r_cnt [N_JOGADORES];
  logic [2:0] r_eleitor;
  logic [2:0] r_alvo;
  logic       r_inv;
  logic [2:0] r_scan;
  logic [2:0] r_max;
  logic [2:0] r_arg;
  logic       r_tie;
  logic [2:0] r_eliminado;
  logic       r_empate;

  logic [2:0] w_prox;
  logic       w_alvo_vivo;
  logic       w_eleitor_vivo;
  logic       w_prox_vivo;
  logic [2:0] w_cnt_sel;
  logic       w_nulo;
  logic       w_valido;
  logic       w_maior;
  logic [2:0] w_max_n;
  logic [2:0] w_arg_n;
  logic       w_tie_n;
  logic       w_abre;

  assign w_prox = r_eleitor + 3'd1;

  always_comb begin
    w_alvo_vivo    = 1'b0;
    w_eleitor_vivo = 1'b0;
    w_prox_vivo    = 1'b0;
    w_cnt_sel      = 3'd0;
    for (int i = 0; i < N_JOGADORES; i++) begin
      if (alvo == 3'(i))      w_alvo_vivo    = r_vivos[i];
      if (r_eleitor == 3'(i)) w_eleitor_vivo = r_vivos[i];
      if (w_prox == 3'(i))    w_prox_vivo    = r_vivos[i];
      if (r_scan == 3'(i))    w_cnt_sel      = r_cnt[i];
    end
  end

`ifdef VOTO_NULO_EN
  assign w_nulo = (alvo == 3'b111);
`else
  assign w_nulo = 1'b0;
`endif

  assign w_valido = w_nulo ||
                    ((alvo < NJ) && w_alvo_vivo &&
                     (alvo != r_eleitor));

  // Only a strictly greater count moves the argmax, so the first seat wins.
  assign w_maior = (w_cnt_sel > r_max);
  assign w_max_n = w_maior ? w_cnt_sel : r_max;
  assign w_arg_n = w_maior ? r_scan : r_arg;
  assign w_tie_n = w_maior ? 1'b0 :
                   ((w_cnt_sel == r_max) && (r_max != 3'd0))
                   ? 1'b1 : r_tie;

  assign w_abre = iniciar &&
                  ((r_estado == OCIOSO) ||
                   (r_estado == RESULTADO));

  always_ff @(posedge clock) begin
    if (reset) r_estado <= OCIOSO;
    else       r_estado <= w_prox_estado;
  end

  always_comb begin
    w_prox_estado = r_estado;
    unique case (r_estado)
      OCIOSO, RESULTADO: begin
        if (iniciar) w_prox_estado = PREPARA;
      end
      PREPARA: begin
        if (r_vivos == '0)       w_prox_estado = APURA;
        else if (w_eleitor_vivo) w_prox_estado = ESPERA_VOTO;
        else                     w_prox_estado = PROXIMO;
      end
      ESPERA_VOTO: begin
        if (confirma && w_valido) w_prox_estado = REGISTRA;
      end
      REGISTRA: w_prox_estado = PROXIMO;
      PROXIMO: begin
        if (w_prox == NJ)     w_prox_estado = APURA;
        else if (w_prox_vivo) w_prox_estado = ESPERA_VOTO;
      end
      APURA: begin
        if (r_scan == ULTIMO) w_prox_estado = RESULTADO;
      end
      default: w_prox_estado = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_vivos     <= '0;
      r_eleitor   <= 3'd0;
      r_alvo      <= 3'd0;
      r_inv       <= 1'b0;
      r_scan      <= 3'd0;
      r_max       <= 3'd0;
      r_arg       <= 3'd0;
      r_tie       <= 1'b0;
      r_eliminado <= 3'b111;
      r_empate    <= 1'b0;
      for (int i = 0; i < N_JOGADORES; i++)
        r_cnt[i] <= 3'd0;
    end else begin
      r_inv <= 1'b0;
      if (w_abre) begin
        r_vivos     <= vivos;
        r_eleitor   <= 3'd0;
        r_scan      <= 3'd0;
        r_max       <= 3'd0;
        r_arg       <= 3'd0;
        r_tie       <= 1'b0;
        r_eliminado <= 3'b111;
        r_empate    <= 1'b0;
        for (int i = 0; i < N_JOGADORES; i++)
          r_cnt[i] <= 3'd0;
      end
      if (r_estado == ESPERA_VOTO && confirma) begin
        if (w_valido) r_alvo <= alvo;
        else          r_inv  <= 1'b1;
      end
      // An abstention (3'b111) matches no seat and leaves every counter alone.
      if (r_estado == REGISTRA) begin
        for (int i = 0; i < N_JOGADORES; i++)
          if (r_alvo == 3'(i)) r_cnt[i] <= r_cnt[i] + 3'd1;
      end
      if (r_estado == PROXIMO) r_eleitor <= w_prox;
      if (r_estado == APURA) begin
        r_scan <= r_scan + 3'd1;
        r_max  <= w_max_n;
        r_arg  <= w_arg_n;
        r_tie  <= w_tie_n;
        if (r_scan == ULTIMO) begin
          if (w_max_n == 3'd0 || w_tie_n) begin
            r_eliminado <= 3'b111;
            r_empate    <= 1'b1;
          end else begin
            r_eliminado <= w_arg_n;
            r_empate    <= 1'b0;
          end
        end
      end
    end
  end

  assign eleitor_atual = r_eleitor;
  assign votando       = (r_estado == ESPERA_VOTO);
  assign voto_invalido = r_inv;
  assign pronto        = (r_estado == RESULTADO);
  assign eliminado     = r_eliminado;
  assign empate        = r_empate;
  assign db_estado     = r_estado;

endmodule

// File: tb/tb_votacao_lobinho.sv
// Directed bench for votacao_lobinho with N_JOGADORES=5.
// Define VOTO_NULO_EN on both files to exercise abstentions.
module tb_votacao_lobinho;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [4:0] vivos = 5'b0;
  logic [2:0] alvo = 3'd0;
  logic       confirma = 1'b0;
  logic [2:0] eleitor_atual;
  logic       votando;
  logic       voto_invalido;
  logic       pronto;
  logic [2:0] eliminado;
  logic       empate;
  logic [3:0] db_estado;

  int n_chk = 0;
  int n_err = 0;
  logic mon_on = 1'b0;
  logic viu_morto = 1'b0;

  votacao_lobinho #(.N_JOGADORES(5)) dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
    .vivos(vivos),
    .alvo(alvo),
    .confirma(confirma),
    .eleitor_atual(eleitor_atual),
    .votando(votando),
    .voto_invalido(voto_invalido),
    .pronto(pronto),
    .eliminado(eliminado),
    .empate(empate),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock)
    if (mon_on && votando &&
        (eleitor_atual == 3'd1 || eleitor_atual == 3'd3))
      viu_morto = 1'b1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  task automatic inicia(input logic [4:0] m);
    vivos = m;
    iniciar = 1'b1;
    tick;
    iniciar = 1'b0;
    chk("prepara", db_estado, 1);
  endtask

  task automatic aguarda_voto(input logic [2:0] quem);
    int k = 0;
    while (!votando && k < 20) begin
      tick;
      k++;
    end
    chk("votando", votando, 1);
    chk("eleitor", eleitor_atual, quem);
  endtask

  task automatic vota(input logic [2:0] quem,
                      input logic [2:0] a);
    aguarda_voto(quem);
    alvo = a;
    confirma = 1'b1;
    tick;
    confirma = 1'b0;
    chk("aceito", voto_invalido, 0);
    chk("registra", db_estado, 3);
  endtask

  task automatic rejeita(input logic [2:0] a);
    alvo = a;
    confirma = 1'b1;
    tick;
    confirma = 1'b0;
    chk("inv_pulso", voto_invalido, 1);
    chk("inv_eleitor", eleitor_atual, 0);
    tick;
    chk("inv_fim", voto_invalido, 0);
    chk("inv_espera", votando, 1);
  endtask

  task automatic aguarda_resultado(input logic [2:0] el,
                                   input logic emp,
                                   input int napura);
    int k = 0;
    int na = 0;
    while (!pronto && k < 40) begin
      if (db_estado == 4'd5) na++;
      tick;
      k++;
    end
    chk("pronto", pronto, 1);
    chk("eliminado", eliminado, el);
    chk("empate", empate, emp);
    chk("apura_ciclos", na, napura);
  endtask

  initial begin
    tick;
    tick;
    reset = 1'b0;
    chk("rst_estado", db_estado, 0);
    chk("rst_votando", votando, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_elim", eliminado, 3'b111);
    chk("rst_empate", empate, 0);
    chk("rst_inv", voto_invalido, 0);
    chk("rst_eleitor", eleitor_atual, 0);

    // clear winner: seat 2 gets three votes
    inicia(5'b11111);
    tick;
    chk("t1_votando", votando, 1);
    vota(0, 2);
    vota(1, 2);
    vota(2, 0);
    vota(3, 2);
    vota(4, 1);
    aguarda_resultado(3'd2, 1'b0, 5);
    tick;
    chk("t1_hold", eliminado, 2);

    // tie between seats 0 and 1, started from RESULTADO
    inicia(5'b01111);
    vota(0, 1);
    vota(1, 0);
    vota(2, 1);
    vota(3, 0);
    aguarda_resultado(3'b111, 1'b1, 5);

    // invalid ballots: dead, self, out of range
    inicia(5'b01111);
    aguarda_voto(0);
    rejeita(3'd4);
    rejeita(3'd0);
    rejeita(3'd6);
    vota(0, 3);
    aguarda_voto(1);
    do_reset;

    // dead seats skipped
    mon_on = 1'b1;
    inicia(5'b10101);
    vota(0, 2);
    vota(2, 4);
    vota(4, 0);
    aguarda_resultado(3'b111, 1'b1, 5);
    mon_on = 1'b0;
    chk("t4_mortos", viu_morto, 0);

    // abstention
    inicia(5'b11111);
`ifdef VOTO_NULO_EN
    for (int i = 0; i < 5; i++) vota(3'(i), 3'b111);
    aguarda_resultado(3'b111, 1'b1, 5);
`else
    aguarda_voto(0);
    rejeita(3'b111);
`endif
    do_reset;

    // reset during voter 2
    inicia(5'b11111);
    vota(0, 1);
    vota(1, 3);
    aguarda_voto(2);
    do_reset;
    chk("t6_estado", db_estado, 0);
    chk("t6_votando", votando, 0);
    chk("t6_pronto", pronto, 0);
    chk("t6_elim", eliminado, 3'b111);
    chk("t6_eleitor", eleitor_atual, 0);
    inicia(5'b11111);
    vota(0, 4);
    vota(1, 4);
    vota(2, 3);
    vota(3, 4);
    vota(4, 3);
    aguarda_resultado(3'd4, 1'b0, 5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
